// File: rtl/i_fetch_ctrl.sv
// i_fetch_ctrl: instruction-fetch sequencer for the basic processor.
// Owns the PC, drives the synchronous ROM address, tracks the single
// outstanding read and buffers returned words in a 2-entry FIFO for decode.
module i_fetch_ctrl #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_q,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_addr,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [DW-1:0] inst,
   output logic [AW-1:0] inst_pc
);

   logic [AW-1:0] pc;
   logic          inflight;
   logic [AW-1:0] inflight_pc;

   logic [DW-1:0] fifo_inst [2];
   logic [AW-1:0] fifo_pc   [2];
   logic          head;
   logic [1:0]    count;

   logic          deq;
   logic          issue;
   logic          push;
   logic          wr_idx;
   logic [2:0]    occupancy;

   // A redirect hides the buffer head so wrong-path words are never consumed
   assign inst_valid = (count != 2'd0) & ~redirect_valid;
   assign deq        = inst_valid & inst_ready & ~redirect_valid;

   // Buffered words plus the outstanding read must fit in the 2 FIFO slots
   assign occupancy  = {1'b0, count} + {2'b00, inflight};
   assign issue      = redirect_valid | (run & ((occupancy < 3'd2) | deq));

   // Redirect target goes straight to the ROM so the branch costs only two bubbles
   assign rom_addr   = redirect_valid ? redirect_addr : pc;

   // The word returning this cycle is wrong-path if a redirect is present
   assign push       = inflight & ~redirect_valid;

   // Tail slot is the one after the head when a single entry is held
   assign wr_idx     = head ^ count[0];

   assign inst       = fifo_inst[head];
   assign inst_pc    = fifo_pc[head];

   // PC and in-flight tracking: each issue records the address whose data returns next cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= '0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (issue) begin
         inflight    <= 1'b1;
         inflight_pc <= rom_addr;
         pc          <= rom_addr + AW'(1);
      end else begin
         inflight    <= 1'b0;
      end
   end

   // Two-entry instruction buffer; a redirect empties it while leaving stale slots untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
         head  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_inst[i] <= '0;
            fifo_pc[i]   <= '0;
         end
      end else if (redirect_valid) begin
         count <= 2'd0;
      end else begin
         if (push) begin
            fifo_inst[wr_idx] <= rom_q;
            fifo_pc[wr_idx]   <= inflight_pc;
         end
         count <= count + {1'b0, push} - {1'b0, deq};
         head  <= head ^ deq;
      end
   end

endmodule

// File: tb/tb_i_fetch_ctrl.sv
// tb_i_fetch_ctrl: directed, table-driven check of the instruction-fetch controller
// with a behavioural one-cycle-latency ROM.
module tb_i_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        run;
   logic [7:0]  romAddr;
   logic [15:0] romQ;
   logic        redirectValid;
   logic [7:0]  redirectAddr;
   logic        instValid;
   logic        instReady;
   logic [15:0] inst;
   logic [7:0]  instPc;

   int checks;
   int errors;

   typedef struct {
      logic       run;
      logic       ready;
      logic       redir;
      logic [7:0] redirAddr;
      logic       expValid;
      logic [7:0] expPc;
      logic [7:0] expAddr;
   } vecT;

   vecT vecs[$];

   i_fetch_ctrl #(.AW(8), .DW(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .rom_addr       (romAddr),
      .rom_q          (romQ),
      .redirect_valid (redirectValid),
      .redirect_addr  (redirectAddr),
      .inst_valid     (instValid),
      .inst_ready     (instReady),
      .inst           (inst),
      .inst_pc        (instPc)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM image: the program words from the test plan, a simple address pattern elsewhere
   function automatic logic [15:0] romWord(input logic [7:0] a);
      case (a)
         8'h00:   romWord = 16'h7107;
         8'h01:   romWord = 16'h7203;
         8'h02:   romWord = 16'h7304;
         8'h03:   romWord = 16'h740D;
         8'h04:   romWord = 16'hC125;
         default: romWord = {a ^ 8'h5A, a};
      endcase
   endfunction

   // Synchronous ROM: registered address, data one cycle later
   always @(posedge clk) romQ <= romWord(romAddr);

   function automatic vecT makeVec(input logic r, input logic rd, input logic rv,
                                   input logic [7:0] ra, input logic ev,
                                   input logic [7:0] ep, input logic [7:0] ea);
      vecT v;
      v.run = r; v.ready = rd; v.redir = rv; v.redirAddr = ra;
      v.expValid = ev; v.expPc = ep; v.expAddr = ea;
      return v;
   endfunction

   task automatic applyStimulus(input logic r, input logic rd, input logic rv,
                                input logic [7:0] ra);
      run           = r;
      instReady     = rd;
      redirectValid = rv;
      redirectAddr  = ra;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic checkVec(input string tag, input vecT v);
      checkOutput({tag, " inst_valid"}, 32'(instValid), 32'(v.expValid));
      checkOutput({tag, " rom_addr"}, 32'(romAddr), 32'(v.expAddr));
      if (v.expValid) begin
         checkOutput({tag, " inst_pc"}, 32'(instPc), 32'(v.expPc));
         checkOutput({tag, " inst"}, 32'(inst), 32'(romWord(v.expPc)));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // run, ready, redirect, redirAddr, expValid, expPc, expRomAddr
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 0, 8'h00, 8'h00)); // c0  first issue
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 0, 8'h00, 8'h01)); // c1
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 1, 8'h00, 8'h02)); // c2  first valid
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 1, 8'h01, 8'h03)); // c3
      vecs.push_back(makeVec(1, 0, 0, 8'h00, 1, 8'h02, 8'h04)); // c4  backpressure
      vecs.push_back(makeVec(1, 0, 0, 8'h00, 1, 8'h02, 8'h04)); // c5  FIFO full
      vecs.push_back(makeVec(1, 0, 0, 8'h00, 1, 8'h02, 8'h04)); // c6
      vecs.push_back(makeVec(1, 0, 0, 8'h00, 1, 8'h02, 8'h04)); // c7
      vecs.push_back(makeVec(1, 0, 0, 8'h00, 1, 8'h02, 8'h04)); // c8
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 1, 8'h02, 8'h04)); // c9  release
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 1, 8'h03, 8'h05)); // c10
      vecs.push_back(makeVec(1, 1, 1, 8'h0A, 0, 8'h00, 8'h0A)); // c11 redirect at head 04
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 0, 8'h00, 8'h0B)); // c12 bubble
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 1, 8'h0A, 8'h0C)); // c13 target
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 1, 8'h0B, 8'h0D)); // c14
      vecs.push_back(makeVec(1, 1, 1, 8'hFE, 0, 8'h00, 8'hFE)); // c15 redirect to FE
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 0, 8'h00, 8'hFF)); // c16
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 1, 8'hFE, 8'h00)); // c17 address wraps
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 1, 8'hFF, 8'h01)); // c18
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 1, 8'h00, 8'h02)); // c19
      vecs.push_back(makeVec(0, 1, 0, 8'h00, 1, 8'h01, 8'h03)); // c20 run dropped
      vecs.push_back(makeVec(0, 1, 0, 8'h00, 1, 8'h02, 8'h03)); // c21 in-flight delivered
      vecs.push_back(makeVec(0, 1, 0, 8'h00, 0, 8'h00, 8'h03)); // c22
      vecs.push_back(makeVec(0, 1, 0, 8'h00, 0, 8'h00, 8'h03)); // c23
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 0, 8'h00, 8'h03)); // c24 restart
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 0, 8'h00, 8'h04)); // c25
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 1, 8'h03, 8'h05)); // c26
      vecs.push_back(makeVec(1, 1, 0, 8'h00, 1, 8'h04, 8'h06)); // c27
      vecs.push_back(makeVec(1, 0, 0, 8'h00, 1, 8'h05, 8'h07)); // c28 fill FIFO
      vecs.push_back(makeVec(1, 0, 0, 8'h00, 1, 8'h05, 8'h07)); // c29 full

      // Reset state
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("reset inst_valid", 32'(instValid), 32'h0);
      checkOutput("reset inst", 32'(inst), 32'h0000);
      checkOutput("reset inst_pc", 32'(instPc), 32'h00);
      checkOutput("reset rom_addr", 32'(romAddr), 32'h00);

      // Table-driven main sequence
      rst = 1'b0;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].run, vecs[i].ready, vecs[i].redir, vecs[i].redirAddr);
         #1;
         checkVec($sformatf("c%0d", i), vecs[i]);
         @(negedge clk);
      end

      // Reset with the FIFO full discards everything
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      #1;
      checkOutput("midrst inst_valid", 32'(instValid), 32'h0);
      checkOutput("midrst inst_pc", 32'(instPc), 32'h00);
      checkOutput("midrst rom_addr", 32'(romAddr), 32'h00);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      #1;
      checkVec("post0", makeVec(1, 1, 0, 8'h00, 0, 8'h00, 8'h00));
      @(negedge clk);
      #1;
      checkVec("post1", makeVec(1, 1, 0, 8'h00, 0, 8'h00, 8'h01));
      @(negedge clk);
      #1;
      checkVec("post2", makeVec(1, 1, 0, 8'h00, 1, 8'h00, 8'h02));
      @(negedge clk);
      #1;
      checkVec("post3", makeVec(1, 1, 0, 8'h00, 1, 8'h01, 8'h03));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i_fetch_ctrl.md
# i_fetch_ctrl

Instruction-fetch controller that sequences the 256×16 synchronous instruction ROM for the basic processor. It owns the program counter, drives the ROM address, and tracks the ROM's one-cycle read latency. Returned words go into a 2-entry buffer that feeds decode through a valid/ready handshake. Decode or execute can redirect it on a taken BEQ, which flushes all wrong-path words.

## Interface
Parameters:
- AW, 8, ROM address / PC width
- DW, 16, instruction width

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- run  in  1  fetch enable; 0 stops new ROM reads without flushing
- rom_addr  out  AW  address to ROM; ROM registers it and returns data the next cycle
- rom_q  in  DW  ROM read data for the address presented in the previous cycle
- redirect_valid  in  1  taken-branch redirect
- redirect_addr  in  AW  redirect target
- inst_valid  out  1  buffer head holds a valid instruction
- inst_ready  in  1  decode accepts head this cycle
- inst  out  DW  head instruction
- inst_pc  out  AW  address the head instruction was fetched from

## Operation
- State:
  - pc (next sequential fetch address)
  - inflight bit plus inflight_pc (one outstanding ROM read)
  - 2-entry FIFO of {inst, pc} with count 0..2
- Dequeue: deq = inst_valid & inst_ready & ~redirect_valid.
- Issue condition: issue = run & ((count + inflight) < 2 | deq). This guarantees the FIFO never overflows.
- rom_addr (combinational):
  - redirect_valid ? redirect_addr : pc.
  - When not issuing, it still equals pc; the returned data is ignored because inflight = 0.
- On issue:
  - inflight <= 1, inflight_pc <= rom_addr, pc <= rom_addr + 1.
  - Addition is mod 256, so 8'hFF wraps to 8'h00.
- No issue: inflight <= 0.
- Capture: if inflight = 1 and no redirect this cycle, push {rom_q, inflight_pc} into the FIFO.
- Push and deq in the same cycle leave count unchanged; the head advances.
- Redirect (redirect_valid = 1):
  - FIFO count <= 0.
  - The in-flight word returning this cycle is discarded.
  - inst_valid is forced to 0 combinationally in that cycle.
  - A fetch of redirect_addr is issued unconditionally, regardless of FIFO state, and even when run = 0.
  - pc <= redirect_addr + 1.
- run = 0: the in-flight read still completes and is pushed; the FIFO continues to drain.
- Opcodes are not decoded here; BEQ resolution is external.

## Timing
- Reset values (cycle after rst sampled high):
  - pc = 0, inflight = 0, count = 0
  - inst_valid = 0, inst = 16'h0000, inst_pc = 8'h00
  - rom_addr = 8'h00
- rst overrides redirect and run. Reset mid-operation discards the FIFO and the in-flight read.
- Issue-to-valid latency: word fetched in cycle T is returned on rom_q in T+1, captured at end of T+1, and shown with inst_valid in T+2.
- Throughput: 1 instruction/cycle while inst_ready is held high. Steady state has count = 1 and inflight = 1.
- Redirect penalty:
  - Redirect in cycle T gives inst_valid = 0 in T and T+1.
  - The target instruction is valid in T+2 with inst_pc = redirect_addr.
- Backpressure: with inst_ready = 0, the FIFO fills to 2 and issue stops.
  - inst and inst_pc are held stable while inst_valid & ~inst_ready.
  - Fetch resumes the cycle inst_ready returns. No word is lost or duplicated.
- Simultaneous redirect and inst_ready: no dequeue occurs; the redirect wins.

## Test plan
- Reset, then run = 1 and inst_ready = 1, with ROM 0..3 = 7107, 7203, 7304, 740D:
  - inst_valid first high 2 cycles after reset release.
  - Outputs {7107,00}, {7203,01}, {7304,02}, {740D,03} on consecutive cycles.
- Backpressure: inst_ready = 0 for 5 cycles mid-stream.
  - Head is held; FIFO count saturates at 2; rom_addr stops advancing.
  - After release, the sequence continues with no gap or duplicate.
- Redirect at the cycle where head = {C125,04}, redirect_addr = 8'h0A:
  - Words from 0x05/0x06 are never presented.
  - inst_valid is low for 2 cycles, then {ROM[0A],0A}.
- Wrap: redirect to 8'hFE with ready held.
  - Outputs have inst_pc FE, FF, 00, 01.
- run dropped for 4 cycles:
  - The in-flight word is still delivered and rom_addr holds.
  - Fetch restarts in order, with no repeated pc.
- rst asserted mid-stream with the FIFO full:
  - Next cycle inst_valid = 0 and pc = 0.
  - After release, the first instruction is {ROM[00],00}.
